// File: rtl/spi_ram_ctrl_if.sv
// Frame/byte bundle between the SPI slave and the RAM controller.
// The SPI slave side is the master; the RAM controller is the slave.
interface spi_ram_ctrl_if;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   modport master (
      output rx_data,
      output rx_valid,
      input  tx_data,
      input  tx_valid
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output tx_data,
      output tx_valid
   );
endinterface

// File: rtl/spi_ram_ctrl.sv
// RAM controller behind the SPI slave: address/data/read commands per frame.
// Optional SPI_RAM_ADDR_AUTO_INC_EN: post-increment wr/rd address on data cmds.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input logic           clk,
   input logic           rst,
   spi_ram_ctrl_if.slave bus
);

   typedef enum logic {IDLE, EXEC} state_t;

   logic [7:0]           mem [MEM_DEPTH];
   state_t               state;
   logic                 rx_valid_q;
   logic [1:0]           cmd_q;
   logic [7:0]           pay_q;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic                 accept;
   logic                 wr_ok;
   logic                 rd_ok;
   logic                 do_write;

   assign accept   = bus.rx_valid & ~rx_valid_q;
   assign wr_ok    = int'(wr_addr) < MEM_DEPTH;
   assign rd_ok    = int'(rd_addr) < MEM_DEPTH;
   assign do_write = !rst && state == EXEC && cmd_q == 2'b01 && wr_ok;

`ifdef SPI_RAM_ADDR_AUTO_INC_EN
   logic [ADDR_SIZE-1:0] wr_next;
   logic [ADDR_SIZE-1:0] rd_next;

   // Wrap at the last real word; past-the-end addresses wrap naturally.
   assign wr_next = (int'(wr_addr) == MEM_DEPTH - 1) ?
                    '0 : wr_addr + ADDR_SIZE'(1);
   assign rd_next = (int'(rd_addr) == MEM_DEPTH - 1) ?
                    '0 : rd_addr + ADDR_SIZE'(1);
`endif

   // Contents survive rst on purpose.
   always_ff @(posedge clk) begin
      if (do_write)
         mem[wr_addr] <= pay_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rx_valid_q   <= 1'b1;
         cmd_q        <= 2'b00;
         pay_q        <= 8'h00;
         wr_addr      <= '0;
         rd_addr      <= '0;
         bus.tx_data  <= 8'h00;
         bus.tx_valid <= 1'b0;
      end else begin
         rx_valid_q <= bus.rx_valid;
         if (accept) begin
            cmd_q        <= bus.rx_data[9:8];
            pay_q        <= bus.rx_data[7:0];
            bus.tx_valid <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (accept)
                  state <= EXEC;
            end
            EXEC: begin
               state <= accept ? EXEC : IDLE;
               unique case (cmd_q)
                  2'b00: begin
                     wr_addr      <= pay_q[ADDR_SIZE-1:0];
                     bus.tx_valid <= 1'b0;
                  end
                  2'b01: begin
                     bus.tx_valid <= 1'b0;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
                     wr_addr <= wr_next;
`endif
                  end
                  2'b10: begin
                     rd_addr      <= pay_q[ADDR_SIZE-1:0];
                     bus.tx_valid <= 1'b0;
                  end
                  2'b11: begin
                     bus.tx_data  <= rd_ok ? mem[rd_addr] : 8'h00;
                     bus.tx_valid <= 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
                     rd_addr <= rd_next;
`endif
                  end
               endcase
            end
         endcase
      end
   end

endmodule
